// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU32 fetch/load-store requesters, the memory port arbiter
// and the single-port memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ready;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              if_err;

    logic              ls_req;
    logic              ls_we;
    logic [3:0]        ls_be;
    logic [31:0]       ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_ready;
    logic              ls_rvalid;
    logic [31:0]       ls_rdata;
    logic              ls_err;

    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Arbiter side: serves both requesters and drives the memory.
    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rvalid, if_rdata, if_err,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output ls_ready, ls_rvalid, ls_rdata, ls_err,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Environment side: requesters plus the memory itself.
    modport master (
        output if_req, if_addr,
        input  if_ready, if_rvalid, if_rdata, if_err,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  ls_ready, ls_rvalid, ls_rdata, ls_err,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and
// load/store, with address checking and a fixed one-cycle response.
module mem_port_arbiter #(
    parameter int MEM_SIZE = 1024,
    parameter int ADDR_W   = 10
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_e;

    localparam logic [30:0] MEM_WORDS = 31'(MEM_SIZE);

    owner_e      last_grant;
    owner_e      last_grant_nxt;

    logic        gnt_if_p0;
    logic        gnt_ls_p0;
    logic [31:0] sel_addr_p0;
    logic        sel_err_p0;

    logic        tag_vld_p1;
    owner_e      tag_owner_p1;
    logic        tag_err_p1;
    logic        tag_wr_p1;
    logic        rd_ok_p1;

    function automatic logic addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ({1'b0, addr[31:2]} >= MEM_WORDS);
    endfunction

    // Stage p0: arbitrate, check the winner's address and issue to memory.
    always_comb begin
        gnt_if_p0      = 1'b0;
        gnt_ls_p0      = 1'b0;
        sel_addr_p0    = 32'h0;
        sel_err_p0     = 1'b0;
        last_grant_nxt = last_grant;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_be     = 4'b0000;
        bus.mem_addr   = '0;
        bus.mem_wdata  = 32'h0;

        // Outputs are forced low while reset is held, including the combinational readies.
        if (reset) begin
            if (bus.if_req && (!bus.ls_req || last_grant == OWNER_LS)) begin
                gnt_if_p0 = 1'b1;
            end else if (bus.ls_req) begin
                gnt_ls_p0 = 1'b1;
            end
        end

        if (gnt_if_p0) begin
            sel_addr_p0    = bus.if_addr;
            last_grant_nxt = OWNER_IF;
        end else if (gnt_ls_p0) begin
            sel_addr_p0    = bus.ls_addr;
            last_grant_nxt = OWNER_LS;
        end

        sel_err_p0 = (gnt_if_p0 || gnt_ls_p0) && addr_bad(sel_addr_p0);

        if ((gnt_if_p0 || gnt_ls_p0) && !sel_err_p0) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = sel_addr_p0[ADDR_W+1:2];
            bus.mem_be   = 4'b1111;
            if (gnt_ls_p0 && bus.ls_we) begin
                bus.mem_we    = 1'b1;
                bus.mem_be    = bus.ls_be;
                bus.mem_wdata = bus.ls_wdata;
            end
        end
    end

    assign bus.if_ready = gnt_if_p0;
    assign bus.ls_ready = gnt_ls_p0;

    // Stage p0 -> p1: capture the grant as a response tag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant   <= OWNER_LS;
            tag_vld_p1   <= 1'b0;
            tag_owner_p1 <= OWNER_IF;
            tag_err_p1   <= 1'b0;
            tag_wr_p1    <= 1'b0;
        end else begin
            last_grant   <= last_grant_nxt;
            tag_vld_p1   <= gnt_if_p0 || gnt_ls_p0;
            tag_owner_p1 <= gnt_ls_p0 ? OWNER_LS : OWNER_IF;
            tag_err_p1   <= sel_err_p0;
            tag_wr_p1    <= gnt_ls_p0 && bus.ls_we;
        end
    end

    // Stage p1: steer memory read data to the tag owner; writes and errors return zero.
    assign rd_ok_p1      = !tag_err_p1 && !tag_wr_p1;

    assign bus.if_rvalid = tag_vld_p1 && (tag_owner_p1 == OWNER_IF);
    assign bus.if_err    = bus.if_rvalid && tag_err_p1;
    assign bus.if_rdata  = (bus.if_rvalid && rd_ok_p1) ? bus.mem_rdata : 32'h0;

    assign bus.ls_rvalid = tag_vld_p1 && (tag_owner_p1 == OWNER_LS);
    assign bus.ls_err    = bus.ls_rvalid && tag_err_p1;
    assign bus.ls_rdata  = (bus.ls_rvalid && rd_ok_p1) ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reference arbitration model, memory model
// and a response scoreboard queue.
module tb_mem_port_arbiter;

    typedef struct {
        bit          owner;
        bit          err;
        logic [31:0] data;
    } resp_t;

    logic        clock;
    logic        reset;
    int          total;
    int          bad;
    bit          lg_ls;
    resp_t       q[$];
    logic [31:0] tbmem [0:1023];
    logic [31:0] sh    [0:1023];
    logic [31:0] rdata_q;

    mem_port_arbiter_if #(.ADDR_W(10)) bus ();

    mem_port_arbiter #(.MEM_SIZE(1024), .ADDR_W(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: synchronous read, byte-enabled write.
    always @(posedge clock) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) tbmem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                rdata_q <= tbmem[bus.mem_addr];
            end
        end
    end
    assign bus.mem_rdata = rdata_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".if_ready"},  32'(bus.if_ready),  32'h0);
        chk({tag, ".ls_ready"},  32'(bus.ls_ready),  32'h0);
        chk({tag, ".if_rvalid"}, 32'(bus.if_rvalid), 32'h0);
        chk({tag, ".ls_rvalid"}, 32'(bus.ls_rvalid), 32'h0);
        chk({tag, ".if_err"},    32'(bus.if_err),    32'h0);
        chk({tag, ".ls_err"},    32'(bus.ls_err),    32'h0);
        chk({tag, ".if_rdata"},  bus.if_rdata,       32'h0);
        chk({tag, ".ls_rdata"},  bus.ls_rdata,       32'h0);
        chk({tag, ".mem_en"},    32'(bus.mem_en),    32'h0);
        chk({tag, ".mem_we"},    32'(bus.mem_we),    32'h0);
        chk({tag, ".mem_be"},    32'(bus.mem_be),    32'h0);
        chk({tag, ".mem_addr"},  32'(bus.mem_addr),  32'h0);
        chk({tag, ".mem_wdata"}, bus.mem_wdata,      32'h0);
    endtask

    task automatic drive_if(input bit req, input logic [31:0] addr);
        bus.if_req  = req;
        bus.if_addr = addr;
    endtask

    task automatic drive_ls(input bit req, input bit we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
        bus.ls_req   = req;
        bus.ls_we    = we;
        bus.ls_be    = be;
        bus.ls_addr  = addr;
        bus.ls_wdata = wdata;
    endtask

    // One clock: check the issue side against the model, queue the expected response,
    // then check the response side after the edge.
    task automatic cycle(input string tag);
        bit          gi, gl, err, en, we, have;
        logic [31:0] a, wd;
        logic [3:0]  be;
        int          w;
        resp_t       r;
        #1;
        gi  = bus.if_req && (!bus.ls_req || lg_ls);
        gl  = bus.ls_req && !gi;
        a   = gi ? bus.if_addr : (gl ? bus.ls_addr : 32'h0);
        err = (gi || gl) && ((a[1:0] != 2'b00) || (a[31:2] >= 30'd1024));
        en  = (gi || gl) && !err;
        we  = en && gl && bus.ls_we;
        be  = !en ? 4'h0 : (we ? bus.ls_be : 4'hF);
        wd  = we ? bus.ls_wdata : 32'h0;
        w   = int'(a[11:2]);
        chk({tag, ".if_ready"}, 32'(bus.if_ready), 32'(gi));
        chk({tag, ".ls_ready"}, 32'(bus.ls_ready), 32'(gl));
        chk({tag, ".mem_en"},   32'(bus.mem_en),   32'(en));
        chk({tag, ".mem_we"},   32'(bus.mem_we),   32'(we));
        chk({tag, ".mem_be"},   32'(bus.mem_be),   32'(be));
        chk({tag, ".mem_addr"}, 32'(bus.mem_addr), en ? 32'(a[11:2]) : 32'h0);
        if (!en || we) chk({tag, ".mem_wdata"}, bus.mem_wdata, wd);
        if (gi || gl) begin
            r.owner = gl;
            r.err   = err;
            r.data  = (err || (gl && bus.ls_we)) ? 32'h0 : sh[w];
            q.push_back(r);
        end
        if (we)
            for (int b = 0; b < 4; b++)
                if (be[b]) sh[w][8*b +: 8] = wd[8*b +: 8];
        if (gi) lg_ls = 1'b0;
        if (gl) lg_ls = 1'b1;

        @(posedge clock);
        #1;
        have = (q.size() > 0);
        if (have) r = q.pop_front();
        else begin r.owner = 1'b0; r.err = 1'b0; r.data = 32'h0; end
        chk({tag, ".if_rvalid"}, 32'(bus.if_rvalid), 32'(have && !r.owner));
        chk({tag, ".ls_rvalid"}, 32'(bus.ls_rvalid), 32'(have && r.owner));
        chk({tag, ".if_err"},    32'(bus.if_err),    32'(have && !r.owner && r.err));
        chk({tag, ".ls_err"},    32'(bus.ls_err),    32'(have && r.owner && r.err));
        chk({tag, ".if_rdata"},  bus.if_rdata, (have && !r.owner) ? r.data : 32'h0);
        chk({tag, ".ls_rdata"},  bus.ls_rdata, (have && r.owner) ? r.data : 32'h0);
    endtask

    task automatic pulse_reset(input string tag);
        drive_if(1'b0, 32'h0);
        drive_ls(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        reset = 1'b0;
        #1;
        chk_zero(tag);
        @(posedge clock);
        #1;
        reset = 1'b1;
        lg_ls = 1'b1;
        q.delete();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        lg_ls = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            tbmem[i] = 32'h0;
            sh[i]    = 32'h0;
        end
        tbmem[4] = 32'h0050_0093;  sh[4] = 32'h0050_0093;
        tbmem[5] = 32'h1234_5678;  sh[5] = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            tbmem[16+i] = 32'hC0DE_0000 + 32'(i * 32'h111);
            sh[16+i]    = 32'hC0DE_0000 + 32'(i * 32'h111);
        end
        rdata_q = 32'h0;
        reset   = 1'b0;
        drive_if(1'b0, 32'h0);
        drive_ls(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        #2;
        chk_zero("reset_idle");
        drive_if(1'b1, 32'h10);
        drive_ls(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
        #1;
        chk_zero("reset_req");
        drive_if(1'b0, 32'h0);
        drive_ls(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Fetch only, granted in the first cycle after reset release.
        drive_if(1'b1, 32'h10);
        cycle("fetch");
        drive_if(1'b0, 32'h0);
        cycle("idle");

        // Continuous contention straight after reset: IF, LS, IF, LS.
        pulse_reset("reset2");
        drive_if(1'b1, 32'h10);
        drive_ls(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
        for (int i = 0; i < 4; i++) cycle($sformatf("contend%0d", i));
        drive_if(1'b0, 32'h0);
        drive_ls(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle("contend_drain");

        // Partial store then load of the same word.
        drive_ls(1'b1, 1'b1, 4'b0011, 32'h20, 32'hAABB_CCDD);
        cycle("store");
        drive_ls(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        cycle("load");
        chk("load_merged", bus.ls_rdata, 32'h0000_CCDD);
        drive_ls(1'b1, 1'b1, 4'b0000, 32'h24, 32'hFFFF_FFFF);
        cycle("store_be0");
        drive_ls(1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
        cycle("load_be0");

        // Error responses: misaligned and out of range.
        drive_ls(1'b1, 1'b0, 4'h0, 32'h22, 32'h0);
        cycle("ls_misaligned");
        drive_ls(1'b1, 1'b1, 4'hF, 32'h21, 32'h5555_5555);
        cycle("st_misaligned");
        drive_ls(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFC, 32'h6666_6666);
        cycle("st_range");
        drive_ls(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive_if(1'b1, 32'h1000);
        cycle("if_range");
        drive_if(1'b1, 32'h0FFC);
        cycle("if_last_word");
        drive_if(1'b0, 32'h0);
        drive_ls(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        cycle("reload");

        // Contention mixing an erroring fetch with a store.
        drive_if(1'b1, 32'h13);
        drive_ls(1'b1, 1'b1, 4'b1100, 32'h28, 32'h1122_3344);
        cycle("mix0");
        cycle("mix1");
        drive_if(1'b0, 32'h0);
        drive_ls(1'b1, 1'b0, 4'h0, 32'h28, 32'h0);
        cycle("mix_load");

        // Reset while a load response is pending: the response must vanish.
        drive_ls(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
        #1;
        chk("rst_mid.ls_ready", 32'(bus.ls_ready), 32'h1);
        reset = 1'b0;
        #1;
        chk_zero("rst_mid_low");
        @(posedge clock);
        #1;
        chk_zero("rst_mid_edge");
        drive_ls(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        reset = 1'b1;
        lg_ls = 1'b1;
        q.delete();
        cycle("rst_mid_after");

        // Lone fetch requester streaming every cycle.
        for (int i = 0; i < 8; i++) begin
            drive_if(1'b1, 32'h40 + 32'(4 * i));
            cycle($sformatf("stream%0d", i));
        end
        drive_if(1'b0, 32'h0);
        cycle("stream_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port program/data memory between the CPU32 instruction-fetch path and the load/store path.
- Accepts at most one access per cycle and grants with round-robin fairness.
- Returns read data, or a write acknowledge, one cycle after the grant.
- Rejects misaligned and out-of-range addresses with an error response and no memory access.

Parameters:
MEM_SIZE, 1024, memory depth in 32-bit words
ADDR_W, 10, word-address width to memory; MEM_SIZE <= 2^ADDR_W

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
if_req  input  1  fetch request
if_addr  input  32  fetch byte address
if_ready  output  1  fetch request accepted this cycle
if_rvalid  output  1  fetch response valid
if_rdata  output  32  fetch read data
if_err  output  1  fetch response is an error (qualified by if_rvalid)
ls_req  input  1  load/store request
ls_we  input  1  1 = store, 0 = load
ls_be  input  4  store byte enables
ls_addr  input  32  load/store byte address
ls_wdata  input  32  store data
ls_ready  output  1  load/store request accepted this cycle
ls_rvalid  output  1  load/store response valid (load data or store ack)
ls_rdata  output  32  load data; 0 for stores and errors
ls_err  output  1  load/store response is an error
mem_en  output  1  memory access strobe
mem_we  output  1  memory write
mem_be  output  4  memory byte enables
mem_addr  output  ADDR_W  memory word address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Handshake
  - A request transfers in a cycle where req && ready.
  - ready is combinational from req and the arbiter state.
  - Requesters hold req, addr, we, be and wdata stable until ready.
  - No back-pressure on responses.
- Arbitration
  - Only one requester asserting req: it is granted.
  - Both asserting req: grant the requester not granted last. The last_grant register updates on every grant.
  - last_grant resets to LS, so fetch wins the first contention.
  - Back-to-back grants every cycle are allowed, including alternating grants under continuous contention.
- Address check on the granted request
  - Error if addr[1:0] != 0, or if addr[31:2] >= MEM_SIZE.
  - On error: ready=1, mem_en=0, no write. The next cycle gives rvalid=1, err=1, rdata=0.
- Issue (granted request, no error)
  - mem_en=1; mem_addr=addr[ADDR_W+1:2].
  - Fetch: mem_we=0, mem_be=4'b1111.
  - Load: mem_we=0, mem_be=4'b1111.
  - Store: mem_we=1, mem_be=ls_be, mem_wdata=ls_wdata.
  - Store with ls_be=0 is still issued and acknowledged.
- Response
  - Registered tag (valid, owner, err, is_write) captures the grant.
  - The cycle after the grant, the owner's rvalid=1.
  - Owner's rdata = mem_rdata for reads and 0 for writes or errors. rdata is driven combinationally from mem_rdata under the tag.
  - The non-owner's rvalid=0 and rdata=0.
  - Latency is exactly 1 cycle. At most one response per cycle; a response and a new grant may occur in the same cycle.
- Idle
  - mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Reset (reset=0)
  - All outputs 0 immediately; tag cleared; last_grant=LS.
  - Reset asserted with a response pending: the response is dropped and never emitted.
  - After reset release, the first grant may occur in the first cycle.
- Reset value of every output is 0.

Test Plan:
- Fetch only: if_req=1, if_addr=0x10 with mem[4]=0x00500093 -> same cycle if_ready=1, mem_en=1, mem_addr=4. Next cycle if_rvalid=1, if_rdata=0x00500093, if_err=0.
- Contention: if_req=ls_req=1 held for 4 cycles after reset -> grants IF, LS, IF, LS. Responses alternate one cycle later. Never two rvalids in one cycle.
- Store then load: ls_we=1, addr=0x20, be=4'b0011, wdata=0xAABBCCDD, then a load from 0x20 with prior mem[8]=0 -> store gives ls_rvalid=1, ls_rdata=0. Load returns 0x0000CCDD.
- Errors, expected err=1, rdata=0, mem_en never asserted:
  - ls_addr=0x22 (misaligned) -> ls_ready=1, mem_en=0, next cycle ls_rvalid=1, ls_err=1.
  - if_addr=0x1000 (word 1024 >= MEM_SIZE) -> if_err=1.
- Reset mid-operation: grant a load at cycle N, drive reset=0 before the next rising edge -> ls_rvalid stays 0. All outputs 0 while reset is low.
- Single requester streaming: if_req=1 for 8 cycles with ls_req=0 -> if_ready=1 every cycle. Sequential if_rvalid pulses with correct data; last_grant never blocks a lone requester.
